pps_monitor: RTL and testbench
==============================

Name: pps_monitor

Overview:
- Receiving end of a PPS link: it measures an incoming pulse-per-second signal against the local clock.
- Timestamps each PPS rising edge with a free-running 32-bit cycle counter. Computes period and error against a programmable nominal, tracks min/max, and runs a lock state machine.
- Exposes all of this through a pipelined Wishbone slave.
- Sits beside the GPS clock core, as its PPS source checker.

Parameters:
- DW, 32, Wishbone data width.
- DEF_NOMINAL, 32'd100_000_000, reset value of the NOMINAL register (clocks per second).
- DEF_TOL, 32'd1000, reset value of the TOLERANCE register (cycles).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous active-high reset.
- i_pps  in  1  asynchronous PPS input.
- i_wb_cyc_stb  in  1  Wishbone cycle and strobe.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  3  register address.
- i_wb_data  in  DW  write data.
- o_wb_ack  out  1  acknowledge.
- o_wb_stall  out  1  stall, tied 0.
- o_wb_data  out  DW  read data.
- o_locked  out  1  high while the state machine is in TRACK.
- o_int  out  1  one-cycle pulse per processed PPS edge or timeout.

Behaviour:
- Reset: o_wb_ack=0, o_wb_data=0, o_locked=0, o_int=0. Internal reset values:
  - state=IDLE, r_now=0, r_last=0.
  - MIN=32'hFFFFFFFF, MAX=0, PERIOD=0, ERR=0.
  - EDGES=0, BAD=0.
  - NOMINAL=DEF_NOMINAL, TOL=DEF_TOL.
  - Reset mid-operation discards all measurement state.
- Input path: 2-FF synchronizer, then rising-edge detect. An i_pps rise sampled at edge k is processed at edge k+3; o_int fires in that same cycle.
- r_now increments every cycle and wraps mod 2^32. Period = r_now - r_last, mod 2^32, so wrap is harmless. ERR = period - NOMINAL, two's complement signed.
- "Good" period: |ERR| <= TOL.
- Every processed edge:
  - r_last <= r_now.
  - EDGES++ (16-bit, saturating).
- State IDLE: on edge go to ACQ; no period measured.
- State ACQ: on edge compute PERIOD and ERR, and update MIN and MAX.
  - Good period: go to TRACK.
  - Bad period: BAD++ (16-bit, saturating), stay in ACQ.
- State TRACK: on edge measure as in ACQ.
  - Good period: stay in TRACK.
  - Bad period: BAD++, go to ACQ.
- Timeout: in ACQ or TRACK, if r_now - r_last > NOMINAL + TOL with no edge:
  - go to LOST, BAD++ once, pulse o_int.
  - An edge in the same cycle takes priority; no timeout is taken.
- State LOST: on edge go to ACQ (r_last captured, no period); no further timeouts.
- o_locked is registered: high the cycle after entering TRACK, low the cycle after leaving it.
- Wishbone:
  - o_wb_ack <= i_wb_cyc_stb, giving 1-cycle latency; o_wb_stall=0.
  - o_wb_data is registered from i_wb_addr every cycle.
- Register map (address: name, access, content):
  - 0: CTRL, r/w. Read {28'h0, state[1:0], o_locked, 1'b0}. Write with bit0=1 clears statistics (MIN, MAX, EDGES, BAD, PERIOD, ERR) and sets state=IDLE.
  - 1: NOMINAL, r/w.
  - 2: TOLERANCE, r/w.
  - 3: PERIOD, read-only.
  - 4: ERR, read-only.
  - 5: MIN, read-only.
  - 6: MAX, read-only.
  - 7: {EDGES, BAD}, read-only.
- Writes to read-only addresses are ignored.
- Snapshot: a read of addr 3 freezes updates of PERIOD, ERR, MIN and MAX until addr 6 is read. The state machine, r_last and counters keep running while frozen.
- Clear coinciding with an edge: the clear wins, and that edge is then processed as the first edge (IDLE -> ACQ, r_last captured, EDGES=1).
- A NOMINAL or TOL write takes effect from the next cycle's comparison.

Decomposition:
- Shared package gps_pkg holds:
  - state encoding: IDLE=0, ACQ=1, TRACK=2, LOST=3;
  - register address constants;
  - DEF_NOMINAL and DEF_TOL.
- One sub-module, pps_sync_edge: 2-FF synchronizer plus rising-edge pulse, with i_clk and i_reset.

Test Plan:
- Setup: NOMINAL=100, TOL=2, i_pps pulse every 100 cycles. Response:
  - after the 2nd edge, state=TRACK, PERIOD=100, ERR=0, o_locked=1;
  - o_int 3 cycles after each rise;
  - EDGES=2, BAD=0.
- While tracking, one interval of 103 cycles. Response: ERR=3, BAD=1, state=ACQ, o_locked=0, MAX=103. Next 100-cycle interval returns to TRACK.
- While tracking, stop i_pps. Response:
  - state=LOST at r_now - r_last = 103, BAD increments by exactly 1, one o_int pulse;
  - a resumed edge gives ACQ.
- Write CTRL=1 in the same cycle an edge is processed. Response: EDGES=1, BAD=0, MIN=FFFFFFFF, MAX=0, state=ACQ.
- Read addr 3, then apply 3 edges at period 101, then read addr 6. Response: the addr 6 read returns the pre-freeze MAX (not 101); addr 7 EDGES reflects all 3 edges; a subsequent addr 3 read returns 101.
- Assert i_reset during TRACK. Response: next cycle o_locked=0, state=IDLE, NOMINAL=DEF_NOMINAL, reads of addr 7 return 0.

Source files
------------

// File: rtl/gps_pkg.sv
// gps_pkg: shared state encoding, register map and defaults for the PPS monitor
package gps_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        LOST  = 2'd3
    } state_t;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_NOMINAL = 3'd1;
    localparam logic [2:0] A_TOL     = 3'd2;
    localparam logic [2:0] A_PERIOD  = 3'd3;
    localparam logic [2:0] A_ERR     = 3'd4;
    localparam logic [2:0] A_MIN     = 3'd5;
    localparam logic [2:0] A_MAX     = 3'd6;
    localparam logic [2:0] A_STAT    = 3'd7;

    localparam logic [31:0] DEF_NOMINAL = 32'd100_000_000;
    localparam logic [31:0] DEF_TOL     = 32'd1000;

endpackage

// File: rtl/pps_sync_edge.sv
// pps_sync_edge: 2-FF synchronizer for the asynchronous PPS input plus registered rising-edge pulse
module pps_sync_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pps,
    output logic o_rise
);

    logic [2:0] sync_q, sync_d;
    logic       rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[1:0], i_pps};
        rise_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/pps_monitor.sv
// pps_monitor: timestamps PPS edges against the local clock, tracks period/error/min/max and lock state,
// and exposes everything through a pipelined Wishbone slave
module pps_monitor
    import gps_pkg::*;
#(
    parameter int          DW          = 32,
    parameter logic [31:0] DEF_NOMINAL = gps_pkg::DEF_NOMINAL,
    parameter logic [31:0] DEF_TOL     = gps_pkg::DEF_TOL
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_pps,
    input  logic          i_wb_cyc_stb,
    input  logic          i_wb_we,
    input  logic [2:0]    i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_wb_ack,
    output logic          o_wb_stall,
    output logic [DW-1:0] o_wb_data,
    output logic          o_locked,
    output logic          o_int
);

    state_t        state_q, state_d, st_b;
    logic [31:0]   now_q, now_d, last_q, last_d;
    logic [31:0]   period_q, period_d, err_q, err_d;
    logic [31:0]   min_q, min_d, max_q, max_d;
    logic [31:0]   nominal_q, nominal_d, tol_q, tol_d;
    logic [15:0]   edges_q, edges_d, bad_q, bad_d, edges_b, bad_b;
    logic          frozen_q, frozen_d, locked_q, locked_d;
    logic          int_q, int_d, ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          pps_rise, wr, rd, clr, good, timeout, measure, frozen, upd;
    logic [31:0]   elapsed, err_new, abs_err;
    logic [32:0]   limit;

    pps_sync_edge u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pps   (i_pps),
        .o_rise  (pps_rise)
    );

    // A clear behaves as if the block were freshly idle, so an edge in the same cycle is the first edge
    always_comb begin
        wr      = i_wb_cyc_stb & i_wb_we;
        rd      = i_wb_cyc_stb & ~i_wb_we;
        clr     = wr && i_wb_addr == A_CTRL && i_wb_data[0];
        elapsed = now_q - last_q;
        err_new = elapsed - nominal_q;
        abs_err = err_new[31] ? -err_new : err_new;
        good    = abs_err <= tol_q;
        limit   = {1'b0, nominal_q} + {1'b0, tol_q};
        st_b    = clr ? IDLE : state_q;
        edges_b = clr ? '0 : edges_q;
        bad_b   = clr ? '0 : bad_q;
        measure = pps_rise && (st_b == ACQ || st_b == TRACK);
        timeout = !pps_rise && (st_b == ACQ || st_b == TRACK) && {1'b0, elapsed} > limit;
        frozen  = frozen_q | (rd && i_wb_addr == A_PERIOD);
        upd     = measure && !frozen;
    end

    always_comb begin
        state_d   = timeout ? LOST :
                    !pps_rise ? st_b :
                    (st_b == IDLE || st_b == LOST) ? ACQ :
                    good ? TRACK : ACQ;
        now_d     = now_q + 32'd1;
        last_d    = pps_rise ? now_q : last_q;
        edges_d   = (pps_rise && edges_b != 16'hFFFF) ? edges_b + 16'd1 : edges_b;
        bad_d     = ((timeout || (measure && !good)) && bad_b != 16'hFFFF) ? bad_b + 16'd1 : bad_b;
        period_d  = clr ? '0 : upd ? elapsed : period_q;
        err_d     = clr ? '0 : upd ? err_new : err_q;
        min_d     = clr ? '1 : (upd && elapsed < min_q) ? elapsed : min_q;
        max_d     = clr ? '0 : (upd && elapsed > max_q) ? elapsed : max_q;
        nominal_d = (wr && i_wb_addr == A_NOMINAL) ? 32'(i_wb_data) : nominal_q;
        tol_d     = (wr && i_wb_addr == A_TOL) ? 32'(i_wb_data) : tol_q;
        frozen_d  = (rd && i_wb_addr == A_MAX) ? 1'b0 : frozen;
    end

    always_comb begin
        locked_d = state_d == TRACK;
        int_d    = pps_rise | timeout;
        ack_d    = i_wb_cyc_stb;
        rdata_d  = '0;
        case (i_wb_addr)
            A_CTRL:    rdata_d = DW'({28'h0, state_q, locked_q, 1'b0});
            A_NOMINAL: rdata_d = DW'(nominal_q);
            A_TOL:     rdata_d = DW'(tol_q);
            A_PERIOD:  rdata_d = DW'(period_q);
            A_ERR:     rdata_d = DW'(err_q);
            A_MIN:     rdata_d = DW'(min_q);
            A_MAX:     rdata_d = DW'(max_q);
            A_STAT:    rdata_d = DW'({edges_q, bad_q});
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            now_q     <= '0;
            last_q    <= '0;
            period_q  <= '0;
            err_q     <= '0;
            min_q     <= '1;
            max_q     <= '0;
            nominal_q <= DEF_NOMINAL;
            tol_q     <= DEF_TOL;
            edges_q   <= '0;
            bad_q     <= '0;
            frozen_q  <= 1'b0;
            locked_q  <= 1'b0;
            int_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            now_q     <= now_d;
            last_q    <= last_d;
            period_q  <= period_d;
            err_q     <= err_d;
            min_q     <= min_d;
            max_q     <= max_d;
            nominal_q <= nominal_d;
            tol_q     <= tol_d;
            edges_q   <= edges_d;
            bad_q     <= bad_d;
            frozen_q  <= frozen_d;
            locked_q  <= locked_d;
            int_q     <= int_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign o_locked   = locked_q;
    assign o_int      = int_q;

endmodule

// File: tb/tb_pps_monitor.sv
// tb_pps_monitor: directed bench for pps_monitor with hand-computed expectations
module tb_pps_monitor;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pps = 1'b0;
    logic        i_wb_cyc_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [2:0]  i_wb_addr = 3'd0;
    logic [31:0] i_wb_data = 32'd0;
    logic        o_wb_ack, o_wb_stall, o_locked, o_int;
    logic [31:0] o_wb_data;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int t_last = 0;

    always #5 clk = ~clk;

    pps_monitor dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_pps        (i_pps),
        .i_wb_cyc_stb (i_wb_cyc_stb),
        .i_wb_we      (i_wb_we),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .o_wb_ack     (o_wb_ack),
        .o_wb_stall   (o_wb_stall),
        .o_wb_data    (o_wb_data),
        .o_locked     (o_locked),
        .o_int        (o_int)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc_n++;
        end
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        i_wb_cyc_stb = 1'b1;
        i_wb_we      = 1'b0;
        i_wb_addr    = a;
        step(1);
        i_wb_cyc_stb = 1'b0;
        chk(tag, o_wb_data, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        i_wb_cyc_stb = 1'b1;
        i_wb_we      = 1'b1;
        i_wb_addr    = a;
        i_wb_data    = d;
        step(1);
        i_wb_cyc_stb = 1'b0;
        i_wb_we      = 1'b0;
    endtask

    // Rise sampled at the next posedge k; o_int must appear right after edge k+3
    task automatic fire(input string tag);
        t_last = cyc_n;
        i_pps = 1'b1;
        step(1);
        i_pps = 1'b0;
        step(2);
        chk({tag, "_int_early"}, {31'd0, o_int}, 32'd0);
        step(1);
        chk({tag, "_int"}, {31'd0, o_int}, 32'd1);
    endtask

    task automatic next_pulse(input string tag, input int p);
        step(t_last + p - cyc_n);
        fire(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(3);
        chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        chk("rst_data", o_wb_data, 32'd0);
        chk("rst_locked", {31'd0, o_locked}, 32'd0);
        chk("rst_int", {31'd0, o_int}, 32'd0);
        i_reset = 1'b0;
        step(1);
        rd_chk("rst_nominal", 3'd1, 32'd100_000_000);
        chk("rd_ack", {31'd0, o_wb_ack}, 32'd1);
        rd_chk("rst_tol", 3'd2, 32'd1000);
        rd_chk("rst_min", 3'd5, 32'hFFFF_FFFF);
        rd_chk("rst_stat", 3'd7, 32'd0);
        wr(3'd1, 32'd100);
        wr(3'd2, 32'd2);
        wr(3'd3, 32'h1234_5678);
        rd_chk("ro_period", 3'd3, 32'd0);
        rd_chk("ro_max", 3'd6, 32'd0);
        rd_chk("nominal", 3'd1, 32'd100);

        fire("p1");
        rd_chk("p1_ctrl", 3'd0, 32'h4);
        next_pulse("p2", 100);
        chk("p2_locked", {31'd0, o_locked}, 32'd1);
        rd_chk("p2_ctrl", 3'd0, 32'hA);
        rd_chk("p2_period", 3'd3, 32'd100);
        rd_chk("p2_err", 3'd4, 32'd0);
        rd_chk("p2_max", 3'd6, 32'd100);
        rd_chk("p2_stat", 3'd7, 32'h0002_0000);

        next_pulse("p3", 100);
        next_pulse("p4", 103);
        chk("p4_locked", {31'd0, o_locked}, 32'd0);
        rd_chk("p4_err", 3'd4, 32'd3);
        rd_chk("p4_max", 3'd6, 32'd103);
        rd_chk("p4_min", 3'd5, 32'd100);
        rd_chk("p4_stat", 3'd7, 32'h0004_0001);
        rd_chk("p4_ctrl", 3'd0, 32'h4);
        next_pulse("p5", 100);
        rd_chk("p5_ctrl", 3'd0, 32'hA);

        step(t_last + 4 + 102 - cyc_n);
        chk("to_pre_int", {31'd0, o_int}, 32'd0);
        chk("to_pre_locked", {31'd0, o_locked}, 32'd1);
        step(1);
        chk("to_int", {31'd0, o_int}, 32'd1);
        chk("to_locked", {31'd0, o_locked}, 32'd0);
        step(1);
        chk("to_int_once", {31'd0, o_int}, 32'd0);
        rd_chk("to_ctrl", 3'd0, 32'hC);
        rd_chk("to_stat", 3'd7, 32'h0005_0002);
        step(150);
        chk("lost_int_quiet", {31'd0, o_int}, 32'd0);
        rd_chk("lost_stat", 3'd7, 32'h0005_0002);
        fire("resume");
        rd_chk("resume_ctrl", 3'd0, 32'h4);
        rd_chk("resume_stat", 3'd7, 32'h0006_0002);
        next_pulse("p7", 100);
        rd_chk("p7_ctrl", 3'd0, 32'hA);

        step(t_last + 100 - cyc_n);
        t_last = cyc_n;
        i_pps = 1'b1;
        step(1);
        i_pps = 1'b0;
        step(2);
        wr(3'd0, 32'd1);
        chk("clr_int", {31'd0, o_int}, 32'd1);
        rd_chk("clr_stat", 3'd7, 32'h0001_0000);
        rd_chk("clr_min", 3'd5, 32'hFFFF_FFFF);
        rd_chk("clr_ctrl", 3'd0, 32'h4);
        rd_chk("clr_period", 3'd3, 32'd0);
        rd_chk("clr_max", 3'd6, 32'd0);

        next_pulse("s0", 100);
        rd_chk("snap_period", 3'd3, 32'd100);
        next_pulse("s1", 101);
        next_pulse("s2", 101);
        next_pulse("s3", 101);
        rd_chk("snap_min", 3'd5, 32'd100);
        rd_chk("snap_max", 3'd6, 32'd100);
        rd_chk("snap_stat", 3'd7, 32'h0005_0000);
        rd_chk("snap_ctrl", 3'd0, 32'hA);
        next_pulse("s4", 101);
        rd_chk("post_period", 3'd3, 32'd101);
        rd_chk("post_err", 3'd4, 32'd1);
        rd_chk("post_max", 3'd6, 32'd101);

        i_reset = 1'b1;
        step(1);
        i_reset = 1'b0;
        chk("mid_rst_locked", {31'd0, o_locked}, 32'd0);
        chk("mid_rst_data", o_wb_data, 32'd0);
        rd_chk("mid_rst_ctrl", 3'd0, 32'd0);
        rd_chk("mid_rst_nominal", 3'd1, 32'd100_000_000);
        rd_chk("mid_rst_stat", 3'd7, 32'd0);
        rd_chk("mid_rst_max", 3'd6, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
